// File: rtl/hbram_native_responder.sv
// BRAM-backed stand-in for the HyperRAM controller's native user port.
// Emulates calibration delay, idle handshake, buffered writes and fixed read latency.
module hbram_native_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int CAL_CYCLES = 64,
    parameter int RD_LATENCY = 4
) (
    input  logic        native_clk,
    input  logic        rst_n,
    output logic        hbc_cal_pass,
    output logic        native_ctrl_idle,
    input  logic        native_ram_en,
    input  logic        native_ram_rdwr,
    input  logic [31:0] native_ram_address,
    input  logic [10:0] native_ram_burst_len,
    output logic        native_wr_buf_ready,
    input  logic        native_wr_en,
    input  logic [31:0] native_wr_data,
    input  logic [3:0]  native_wr_datamask,
    output logic        native_rd_valid,
    output logic [31:0] native_rd_data,
    output logic        proto_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CAL_W = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES + 1) : 1;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_CAL,
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD
    } state_t;

    state_t                state;
    logic [CAL_W-1:0]      cal_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [10:0]           beats_left;
    logic [ADDR_WIDTH-1:0] cmd_word;
    logic                  wr_fire;
    logic                  unused_addr_bits;
    logic [31:0]           mem [DEPTH];

    assign cmd_word         = native_ram_address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{native_ram_address[31:ADDR_WIDTH+2], native_ram_address[1:0]};

    always_comb begin
        wr_fire = 1'b0;
        if (state == ST_WR && native_wr_en)
            wr_fire = 1'b1;
    end

    // Array is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge native_clk) begin
        if (wr_fire) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!native_wr_datamask[b])
                    mem[word_addr][8*b +: 8] <= native_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge native_clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_CAL;
            cal_cnt             <= '0;
            lat_cnt             <= '0;
            word_addr           <= '0;
            beats_left          <= '0;
            hbc_cal_pass        <= 1'b0;
            native_ctrl_idle    <= 1'b0;
            native_wr_buf_ready <= 1'b0;
            native_rd_valid     <= 1'b0;
            native_rd_data      <= '0;
            proto_err           <= 1'b0;
        end else begin
            if (native_ram_en && state != ST_IDLE)
                proto_err <= 1'b1;
            if (native_wr_en && state != ST_WR)
                proto_err <= 1'b1;

            case (state)
                ST_CAL: begin
                    if (cal_cnt == CAL_W'(CAL_CYCLES - 1)) begin
                        hbc_cal_pass     <= 1'b1;
                        native_ctrl_idle <= 1'b1;
                        state            <= ST_IDLE;
                    end else begin
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (native_ram_en) begin
                        if (native_ram_burst_len == '0) begin
                            proto_err <= 1'b1;
                        end else begin
                            word_addr        <= cmd_word;
                            beats_left       <= native_ram_burst_len;
                            native_ctrl_idle <= 1'b0;
                            if (native_ram_rdwr) begin
                                lat_cnt <= LAT_W'(RD_LATENCY - 2);
                                state   <= ST_RD_WAIT;
                            end else begin
                                native_wr_buf_ready <= 1'b1;
                                state               <= ST_WR;
                            end
                        end
                    end
                end

                ST_WR: begin
                    if (native_wr_en) begin
                        word_addr  <= word_addr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == 11'd1) begin
                            native_wr_buf_ready <= 1'b0;
                            native_ctrl_idle    <= 1'b1;
                            state               <= ST_IDLE;
                        end
                    end
                end

                // Wait count is set so the first beat lands RD_LATENCY cycles after the command.
                ST_RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        native_rd_valid <= 1'b1;
                        native_rd_data  <= mem[word_addr];
                        word_addr       <= word_addr + 1'b1;
                        beats_left      <= beats_left - 1'b1;
                        state           <= ST_RD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ST_RD: begin
                    if (beats_left == '0) begin
                        native_rd_valid  <= 1'b0;
                        native_ctrl_idle <= 1'b1;
                        state            <= ST_IDLE;
                    end else begin
                        native_rd_data <= mem[word_addr];
                        word_addr      <= word_addr + 1'b1;
                        beats_left     <= beats_left - 1'b1;
                    end
                end

                default: state <= ST_CAL;
            endcase
        end
    end

endmodule

// File: tb/tb_hbram_native_responder.sv
// Directed bench for hbram_native_responder: shadow memory model plus per-cycle read checker.
module tb_hbram_native_responder;

    localparam int AW    = 8;
    localparam int CALC  = 8;
    localparam int RDL   = 4;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cal_pass, ctrl_idle, wr_buf_ready, rd_valid, proto_err;
    logic        en = 1'b0, rdwr = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, wr_data = '0, rd_data;
    logic [10:0] burst_len = '0;
    logic [3:0]  wr_mask = '0;

    always #5 clk = ~clk;

    hbram_native_responder #(.ADDR_WIDTH(AW), .CAL_CYCLES(CALC), .RD_LATENCY(RDL)) dut (
        .native_clk(clk), .rst_n(rst_n), .hbc_cal_pass(cal_pass), .native_ctrl_idle(ctrl_idle),
        .native_ram_en(en), .native_ram_rdwr(rdwr), .native_ram_address(address),
        .native_ram_burst_len(burst_len), .native_wr_buf_ready(wr_buf_ready),
        .native_wr_en(wr_en), .native_wr_data(wr_data), .native_wr_datamask(wr_mask),
        .native_rd_valid(rd_valid), .native_rd_data(rd_data), .proto_err(proto_err)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf [16];
    bit          exp_v [int];
    logic [31:0] exp_d [int];
    logic [31:0] exp_hold = '0;
    logic [31:0] rcv [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Read-side checker: valid/data every cycle out of reset; data holds between bursts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_v.exists(cyc)) begin
                chk("rd_valid", {31'd0, rd_valid}, 32'd1);
                chk("rd_data", rd_data, exp_d[cyc]);
                exp_hold = exp_d[cyc];
                rcv.push_back(rd_data);
            end else begin
                chk("rd_valid_low", {31'd0, rd_valid}, 32'd0);
                chk("rd_data_hold", rd_data, exp_hold);
            end
        end
    end

    task automatic reset_and_cal(input bit poke);
        int  n;
        bit  done;
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0;
        exp_v.delete(); exp_d.delete(); exp_hold = '0;
        #1;
        chk("rst_rd_valid_now", {31'd0, rd_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cal_pass", {31'd0, cal_pass}, 32'd0);
        chk("rst_idle", {31'd0, ctrl_idle}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_buf_ready}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_proto", {31'd0, proto_err}, 32'd0);
        rst_n = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < CALC + 20) begin
            @(posedge clk);
            n++;
            #1;
            if (cal_pass) done = 1'b1;
            else begin
                chk("cal_outputs_low", {29'd0, wr_buf_ready, ctrl_idle, rd_valid}, 32'd0);
                en = poke && (n == 2);
                rdwr = 1'b1; burst_len = 11'd1;
            end
        end
        en = 1'b0;
        if (!done) chk("cal_timeout", {31'd0, cal_pass}, 32'd1);
        chk("cal_latency", n, CALC);
        chk("cal_idle_rise", {31'd0, ctrl_idle}, 32'd1);
        chk("cal_proto", {31'd0, proto_err}, {31'd0, poke});
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [3:0] mask,
                               input int stall_at);
        int w = int'(addr[AW+1:2]);
        @(posedge clk); #1;
        chk("wr_cmd_idle", {31'd0, ctrl_idle}, 32'd1);
        en = 1'b1; rdwr = 1'b0; address = addr; burst_len = 11'(len);
        @(posedge clk); #1;
        en = 1'b0;
        chk("wr_ready_rise", {31'd0, wr_buf_ready}, 32'd1);
        chk("wr_idle_drop", {31'd0, ctrl_idle}, 32'd0);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                wr_en = 1'b0; en = 1'b1; rdwr = 1'b1; address = 32'h0; burst_len = 11'd2;
                @(posedge clk); #1;
                en = 1'b0;
                chk("wr_stall_ready", {31'd0, wr_buf_ready}, 32'd1);
                chk("proto_en_in_wr", {31'd0, proto_err}, 32'd1);
            end
            wr_en = 1'b1; wr_data = wbuf[i]; wr_mask = mask;
            @(posedge clk);
            for (int b = 0; b < 4; b++)
                if (!mask[b]) model_mem[(w + i) % DEPTH][8*b +: 8] = wbuf[i][8*b +: 8];
            #1;
            if (i != len - 1) chk("wr_ready_hold", {31'd0, wr_buf_ready}, 32'd1);
        end
        wr_en = 1'b0;
        chk("wr_ready_fall", {31'd0, wr_buf_ready}, 32'd0);
        chk("wr_done_idle", {31'd0, ctrl_idle}, 32'd1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len);
        int w = int'(addr[AW+1:2]);
        int c;
        rcv.delete();
        @(posedge clk); #1;
        chk("rd_cmd_idle", {31'd0, ctrl_idle}, 32'd1);
        en = 1'b1; rdwr = 1'b1; address = addr; burst_len = 11'(len);
        c = cyc;
        for (int i = 0; i < len; i++) begin
            exp_v[c + RDL + i] = 1'b1;
            exp_d[c + RDL + i] = model_mem[(w + i) % DEPTH];
        end
        @(posedge clk); #1;
        en = 1'b0;
        chk("rd_idle_drop", {31'd0, ctrl_idle}, 32'd0);
        repeat (RDL + len - 1) @(posedge clk);
        #1;
        chk("rd_done_idle", {31'd0, ctrl_idle}, 32'd1);
        chk("rd_beat_count", rcv.size(), len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        // T1: calibration timing from reset release
        reset_and_cal(1'b0);

        // T2: four-word write then read
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        write_burst(32'h0, 4, 4'b0000, -1);
        read_burst(32'h0, 4);
        chk("t2_beat0", rcv[0], 32'h11111111);
        chk("t2_beat1", rcv[1], 32'h22222222);
        chk("t2_beat2", rcv[2], 32'h33333333);
        chk("t2_beat3", rcv[3], 32'h44444444);

        // T3: byte mask over zero
        wbuf[0] = 32'h0;
        write_burst(32'h100, 1, 4'b0000, -1);
        wbuf[0] = 32'hAABBCCDD;
        write_burst(32'h100, 1, 4'b0101, -1);
        chk("t3_model_pin", model_mem[64], 32'hAA00CC00);
        read_burst(32'h100, 1);
        chk("t3_masked", rcv[0], 32'hAA00CC00);

        // T4: wrap at top of array
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        write_burst(32'h3F8, 4, 4'b0000, -1);
        read_burst(32'h3F8, 4);
        chk("t4_top_m2", rcv[0], 32'hC0DE0000);
        chk("t4_top_m1", rcv[1], 32'hC0DE0001);
        chk("t4_wrap0", rcv[2], 32'hC0DE0002);
        chk("t4_wrap1", rcv[3], 32'hC0DE0003);
        read_burst(32'h0, 4);
        chk("t4_word0", rcv[0], 32'hC0DE0002);
        chk("t4_word2", rcv[2], 32'h33333333);
        chk("proto_clean", {31'd0, proto_err}, 32'd0);

        // T5: command during a write burst is ignored and flagged
        for (int i = 0; i < 3; i++) wbuf[i] = 32'h5A5A0001 + 32'(i);
        write_burst(32'h40, 3, 4'b0000, 1);
        read_burst(32'h40, 3);
        chk("t5_beat0", rcv[0], 32'h5A5A0001);
        chk("t5_beat2", rcv[2], 32'h5A5A0003);

        // T6: reset in the middle of a read burst, command during calibration
        @(posedge clk); #1;
        en = 1'b1; rdwr = 1'b1; address = 32'h3F8; burst_len = 11'd8;
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            exp_v[c + RDL + i] = 1'b1;
            exp_d[c + RDL + i] = model_mem[(254 + i) % DEPTH];
        end
        @(posedge clk); #1;
        en = 1'b0;
        repeat (RDL + 1) @(posedge clk);
        #1;
        chk("t6_midburst_valid", {31'd0, rd_valid}, 32'd1);
        reset_and_cal(1'b1);
        repeat (RDL + 8) @(posedge clk);
        read_burst(32'h3F8, 4);
        chk("t6_mem_retained", rcv[1], 32'hC0DE0001);

        // zero-length command
        reset_and_cal(1'b0);
        @(posedge clk); #1;
        en = 1'b1; rdwr = 1'b1; address = 32'h100; burst_len = 11'd0;
        @(posedge clk); #1;
        en = 1'b0;
        chk("zlen_proto", {31'd0, proto_err}, 32'd1);
        chk("zlen_idle", {31'd0, ctrl_idle}, 32'd1);
        repeat (RDL + 2) @(posedge clk);
        read_burst(32'h100, 1);
        chk("zlen_then_read", rcv[0], 32'hAA00CC00);

        // write beat outside a write burst
        reset_and_cal(1'b0);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 32'hDEADBEEF; wr_mask = 4'b0000;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("stray_wr_proto", {31'd0, proto_err}, 32'd1);
        chk("stray_wr_ready", {31'd0, wr_buf_ready}, 32'd0);
        read_burst(32'h3F8, 4);
        chk("stray_wr_ignored", rcv[2], 32'hC0DE0002);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
